// File: rtl/gol_gen_ctrl.sv
// Generation controller for an N x N Game of Life board.
// Two ping-pong banks hold the current and next generation; a STEP scans one
// cell per clock into the next bank, then flips the bank select.
module gol_gen_ctrl #(
   parameter int N     = 16,
   parameter int CNT_W = 9,
   parameter int GEN_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [1:0]               cmd_op,
   input  logic [2*$clog2(N)-1:0]   cmd_addr,
   input  logic                     cmd_data,
   input  logic [2*$clog2(N)-1:0]   rd_addr,
   output logic                     rd_data,
   output logic                     busy,
   output logic                     done,
   output logic [CNT_W-1:0]         birth_cnt,
   output logic [CNT_W-1:0]         death_cnt,
   output logic [GEN_W-1:0]         gen_cnt
);

   localparam int LOG_N = $clog2(N);
   localparam int IDX_W = 2 * LOG_N;
   localparam int CELLS = N * N;

   localparam logic [1:0] OP_CLEAR = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_STEP  = 2'b10;

   typedef enum logic [1:0] {IDLE, SCAN, SWAP} state_t;

   state_t             state_q, state_d;
   logic [CELLS-1:0]   bank0_q, bank0_d;
   logic [CELLS-1:0]   bank1_q, bank1_d;
   logic               sel_q, sel_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               done_q, done_d;
   logic [CNT_W-1:0]   birth_q, birth_d;
   logic [CNT_W-1:0]   death_q, death_d;
   logic [GEN_W-1:0]   gen_q, gen_d;

   logic [CELLS-1:0]   cur_bank;
   logic [LOG_N-1:0]   row, col;
   logic [3:0]         nbr_cnt;
   logic [IDX_W-1:0]   nb_idx;
   logic               cur_cell, next_cell;
   int                 r, c;

   assign cur_bank  = sel_q ? bank1_q : bank0_q;
   assign row       = idx_q[IDX_W-1:LOG_N];
   assign col       = idx_q[LOG_N-1:0];
   assign cur_cell  = cur_bank[idx_q];
   assign rd_data   = cur_bank[rd_addr];
   assign cmd_ready = (state_q == IDLE);
   assign busy      = (state_q == SCAN) || (state_q == SWAP);
   assign done      = done_q;
   assign birth_cnt = birth_q;
   assign death_cnt = death_q;
   assign gen_cnt   = gen_q;

   // Count live neighbours of the scanned cell; off-board positions read as dead.
   always_comb begin
      nbr_cnt = '0;
      nb_idx  = '0;
      r       = 0;
      c       = 0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            r = int'(row) + dr;
            c = int'(col) + dc;
            if (!(dr == 0 && dc == 0) && r >= 0 && r < N && c >= 0 && c < N) begin
               nb_idx  = IDX_W'(r * N + c);
               nbr_cnt = nbr_cnt + {3'b000, cur_bank[nb_idx]};
            end
         end
      end
      next_cell = (nbr_cnt == 4'd3) || (cur_cell && nbr_cnt == 4'd2);
   end

   // Command decode, scan sequencing and bank/counter next-state.
   always_comb begin
      state_d = state_q;
      bank0_d = bank0_q;
      bank1_d = bank1_q;
      sel_d   = sel_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      birth_d = birth_q;
      death_d = death_q;
      gen_d   = gen_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               case (cmd_op)
                  OP_CLEAR: begin
                     bank0_d = '0;
                     bank1_d = '0;
                     birth_d = '0;
                     death_d = '0;
                     gen_d   = '0;
                     done_d  = 1'b1;
                  end
                  OP_WRITE: begin
                     if (sel_q) bank1_d[cmd_addr] = cmd_data;
                     else       bank0_d[cmd_addr] = cmd_data;
                     done_d = 1'b1;
                  end
                  OP_STEP: begin
                     birth_d = '0;
                     death_d = '0;
                     idx_d   = '0;
                     state_d = SCAN;
                  end
                  default: ;
               endcase
            end
         end
         SCAN: begin
            if (sel_q) bank0_d[idx_q] = next_cell;
            else       bank1_d[idx_q] = next_cell;
            if (!cur_cell && next_cell) birth_d = birth_q + CNT_W'(1);
            if (cur_cell && !next_cell) death_d = death_q + CNT_W'(1);
            if (idx_q == IDX_W'(CELLS - 1)) state_d = SWAP;
            else                            idx_d   = idx_q + IDX_W'(1);
         end
         SWAP: begin
            sel_d   = ~sel_q;
            gen_d   = gen_q + GEN_W'(1);
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // All state registers; reset aborts any step and zeroes both banks.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         bank0_q <= '0;
         bank1_q <= '0;
         sel_q   <= 1'b0;
         idx_q   <= '0;
         done_q  <= 1'b0;
         birth_q <= '0;
         death_q <= '0;
         gen_q   <= '0;
      end else begin
         state_q <= state_d;
         bank0_q <= bank0_d;
         bank1_q <= bank1_d;
         sel_q   <= sel_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         birth_q <= birth_d;
         death_q <= death_d;
         gen_q   <= gen_d;
      end
   end

endmodule
